// File: rtl/fpu_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_arbiter_pkg: shared types and defaults for the FPU arbiter slice.
// Revision 1.0
// ----------------------------------------------------------------------------
package fpu_arbiter_pkg;

  localparam int FPU_OP_WIDTH       = 2;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [FPU_OP_WIDTH-1:0] {
    NOP  = 2'd0,
    ADD  = 2'd1,
    MULT = 2'd2
  } fpu_operation_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } arb_state_t;

  // The unused encoding 2'b11 collapses to NOP so it completes locally.
  function automatic fpu_operation_t legalize_op(input logic [FPU_OP_WIDTH-1:0] op);
    case (op)
      2'd1:    return ADD;
      2'd2:    return MULT;
      default: return NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_arbiter_if: requester and FPU-core stb/ack signals around the arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
interface fpu_arbiter_if
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [NUM_REQ-1:0]              req_stb;
  logic [NUM_REQ*FPU_OP_WIDTH-1:0] req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b;
  logic [NUM_REQ-1:0]              req_ack;
  logic [NUM_REQ-1:0]              rsp_stb;
  logic [DATA_WIDTH-1:0]           rsp_z;
  logic [NUM_REQ-1:0]              rsp_ack;

  logic [DATA_WIDTH-1:0] add_input_a, add_input_b, add_output_z;
  logic                  add_input_stb, add_input_ack, add_output_stb, add_output_ack;
  logic [DATA_WIDTH-1:0] mul_input_a, mul_input_b, mul_output_z;
  logic                  mul_input_stb, mul_input_ack, mul_output_stb, mul_output_ack;

  // slave: the arbiter; master: requesters plus the two cores.
  modport slave (
    input  req_stb, req_op, req_a, req_b, rsp_ack,
    input  add_input_ack, add_output_z, add_output_stb,
    input  mul_input_ack, mul_output_z, mul_output_stb,
    output req_ack, rsp_stb, rsp_z,
    output add_input_a, add_input_b, add_input_stb, add_output_ack,
    output mul_input_a, mul_input_b, mul_input_stb, mul_output_ack
  );

  modport master (
    output req_stb, req_op, req_a, req_b, rsp_ack,
    output add_input_ack, add_output_z, add_output_stb,
    output mul_input_ack, mul_output_z, mul_output_stb,
    input  req_ack, rsp_stb, rsp_z,
    input  add_input_a, add_input_b, add_input_stb, add_output_ack,
    input  mul_input_a, mul_input_b, mul_input_stb, mul_output_ack
  );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter_rr_grant.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_arbiter_rr_grant: first set request at or after rr_ptr, modulo NUM_REQ.
// Revision 1.0
// ----------------------------------------------------------------------------
module fpu_arbiter_rr_grant #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_arbiter: round-robin sharing of one adder and one multiplier core.
// Revision 1.0
// ----------------------------------------------------------------------------
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  fpu_arbiter_if.slave               bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [CNT_WIDTH-1:0]       op_count
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t              r_state, w_next;
  fpu_operation_t          r_op, w_sel_op;
  logic [DATA_WIDTH-1:0]   r_a, r_b, r_z, w_out_z;
  logic [IDX_W-1:0]        r_grant, r_rr_ptr, w_grant_idx;
  logic [NUM_REQ-1:0]      r_req_ack, w_rsp_stb;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_out_ack;
  logic                    w_grant_valid, w_is_mul, w_in_ack, w_out_stb, w_rsp_ack;
  logic                    w_add_stb, w_mul_stb;

  fpu_arbiter_rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .req         (bus.req_stb),
    .rr_ptr      (r_rr_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_sel_op  = legalize_op(bus.req_op[w_grant_idx*FPU_OP_WIDTH +: FPU_OP_WIDTH]);
  assign w_is_mul  = (r_op == MULT);
  assign w_in_ack  = w_is_mul ? bus.mul_input_ack  : bus.add_input_ack;
  assign w_out_stb = w_is_mul ? bus.mul_output_stb : bus.add_output_stb;
  assign w_out_z   = w_is_mul ? bus.mul_output_z   : bus.add_output_z;
  assign w_rsp_ack = bus.rsp_ack[r_grant];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_add_stb = 1'b0;
    w_mul_stb = 1'b0;
    w_rsp_stb = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) w_next = (w_sel_op == NOP) ? RETURN : ISSUE;
      end
      ISSUE: begin
        w_add_stb = (r_op == ADD);
        w_mul_stb = w_is_mul;
        if (w_in_ack) w_next = WAIT;
      end
      WAIT: begin
        if (w_out_stb) w_next = RETURN;
      end
      RETURN: begin
        w_rsp_stb = NUM_REQ'(1) << r_grant;
        if (w_rsp_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers; req_ack and output_ack are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op      <= NOP;
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= '0;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_req_ack <= '0;
      r_out_ack <= 1'b0;
      r_count   <= '0;
    end else begin
      r_req_ack <= '0;
      r_out_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_grant   <= w_grant_idx;
            r_op      <= w_sel_op;
            r_a       <= bus.req_a[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_b       <= bus.req_b[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_req_ack <= NUM_REQ'(1) << w_grant_idx;
            if (w_sel_op == NOP) r_z <= '0;
          end
        end
        WAIT: begin
          if (w_out_stb) begin
            r_z       <= w_out_z;
            r_out_ack <= 1'b1;
          end
        end
        RETURN: begin
          if (w_rsp_ack) begin
            r_count  <= r_count + CNT_WIDTH'(1);
            r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack        = r_req_ack;
  assign bus.rsp_stb        = w_rsp_stb;
  assign bus.rsp_z          = r_z;
  assign bus.add_input_a    = r_a;
  assign bus.add_input_b    = r_b;
  assign bus.add_input_stb  = w_add_stb;
  assign bus.add_output_ack = r_out_ack && (r_op == ADD);
  assign bus.mul_input_a    = r_a;
  assign bus.mul_input_b    = r_b;
  assign bus.mul_input_stb  = w_mul_stb;
  assign bus.mul_output_ack = r_out_ack && w_is_mul;

  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant;
  assign op_count = r_count;
endmodule
`default_nettype wire

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one single-precision adder core and one multiplier core among NUM_REQ requesters. Each core uses the stb/ack handshake: input_stb/input_ack, then output_stb/output_ack.
- Round-robin grant; one operation in flight at a time. Each request is routed by op: ADD to the adder, MULT to the multiplier, NOP completes locally.
- Sits between the matrix-multiply element engines and the FPU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand and result width (IEEE 754 single).
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-low reset.
- req_stb  in  NUM_REQ  per-requester request valid.
- req_op  in  NUM_REQ*2  per-requester fpu_operation_t.
- req_a, req_b  in  NUM_REQ*DATA_WIDTH  per-requester operands.
- req_ack  out  NUM_REQ  one-cycle request-accepted pulse.
- rsp_stb  out  NUM_REQ  result valid for the granted requester.
- rsp_z  out  DATA_WIDTH  result value, shared by all requesters.
- rsp_ack  in  NUM_REQ  result consumed.
- add_input_a, add_input_b  out  DATA_WIDTH  adder operands.
- add_input_stb  out  1  adder input strobe.
- add_input_ack  in  1  adder input accepted.
- add_output_z  in  DATA_WIDTH  adder result.
- add_output_stb  in  1  adder result valid.
- add_output_ack  out  1  adder result consumed.
- mul_*  same seven signals as add_*, for the multiplier.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner.
- op_count  out  CNT_WIDTH  completed operations; wraps to 0.

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, state IDLE, rr_ptr 0, op_count 0, in-flight op discarded. Cores are reset on the same cycle by the system.
- IDLE:
  - Grant goes to the first requester with req_stb=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch op/a/b and grant_id.
  - Next cycle: req_ack[g]=1 for exactly one cycle; state ISSUE, or RETURN for NOP with rsp_z=0.
  - No request: stay IDLE.
- Requester rules:
  - Hold stb, op and operands stable until req_ack is seen.
  - Hold rsp_ack until rsp_stb drops.
  - req_stb is ignored outside IDLE; no re-arbitration while busy.
- ISSUE:
  - Drive the selected core's input_a/b from the latched operands with input_stb=1.
  - Stay in ISSUE until that core's input_ack is sampled 1.
  - Next cycle: input_stb=0, state WAIT. The unselected core's stb stays 0.
- WAIT:
  - On the selected core's output_stb==1, capture output_z into rsp_z.
  - Assert the core's output_ack for exactly one cycle; state RETURN.
- RETURN:
  - rsp_stb[g]=1 with rsp_z stable until rsp_ack[g] is sampled 1.
  - Next cycle: rsp_stb=0, op_count+1 (0xFFFF wraps to 0), rr_ptr=(g+1) mod NUM_REQ, state IDLE.
- Minimum latency from req_stb to rsp_stb: 4 cycles plus core latency. A NOP takes 2 cycles.
- Simultaneous requests: only the winner is acked; losers hold stb and win in later rounds. Starvation bound is NUM_REQ-1 operations.
- Illegal op encoding (2'b11) is treated as NOP.
- rsp_ack on a non-granted index is ignored.
- Back-to-back: a re-request by the same requester is granted only if no other requester is pending at rr_ptr or later.

Decomposition:
- fpu_pkg:
  - fpu_operation_t (NOP, ADD, MULT) — existing.
  - arb_state_t (IDLE, ISSUE, WAIT, RETURN) — new.
  - FPU_OP_WIDTH=2 — new.
- global_defs: NUM_REQ default.
- Sub-module fpu_rr_grant: combinational first-set search from rr_ptr over req_stb, returning grant_valid and grant_idx. Separately unit-testable.

Test Plan:
- Req0 ADD a=0x3FC00000 (1.5), b=0x40100000 (2.25) -> add_input_stb with those operands; rsp_stb[0] with rsp_z=0x40700000 (3.75); op_count=1; mul_input_stb never asserted.
- Req2 MULT same operands -> mul path used; rsp_z=0x40580000 (3.375); grant_id=2; add_* idle.
- All 4 requesters assert ADD together, holding stb, with rr_ptr=0 -> grants in order 0,1,2,3; each req_ack is a single pulse; rr_ptr ends at 0; op_count=4.
- Req1 NOP -> req_ack[1] one cycle after stb, rsp_stb[1] with rsp_z=0, no core strobes; total 2 cycles to rsp_stb.
- rst driven low during WAIT -> next cycle: busy=0, all stb/ack outputs 0, op_count=0. A fresh ADD after reset completes correctly.
- Preload op_count=0xFFFF via 65535 NOPs, then one more NOP -> op_count=0.
